// File: rtl/i2c_master_seq.sv
// rtl/i2c_master_seq.sv - byte-level I2C master sequencer executing START/WRITE/READ/STOP commands
// Optional clock stretching in q2 of every phase: define I2C_MASTER_STRETCH_EN.
module i2c_master_seq #(
  parameter int CLK_DIV = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       cmd_valid_i,
  input  logic [1:0] cmd_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_last_i,
  output logic       cmd_ready_o,
  output logic       done_o,
  output logic [7:0] rd_data_o,
  output logic       nack_o,
  output logic       err_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_WRITE = 2'd1;
  localparam logic [1:0] C_STOP  = 2'd3;
`ifdef I2C_MASTER_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam logic [9:0] Q_LAST = 10'(CLK_DIV - 1);
  localparam logic [9:0] Q_FIN  = 10'(CLK_DIV - 2);

  state_t     state;
  logic [9:0] cnt;
  logic [1:0] qtr;
  logic [3:0] bit_idx;
  logic       is_wr;
  logic       last_r;
  logic       ack_s;
  logic [7:0] sh;
  logic       stall;
  logic       q_end;
  logic       fin;
  logic       nbit_oe;

  assign stall = STRETCH && (qtr == 2'd2) && !scl_i;
  assign q_end = (cnt == Q_LAST) && !stall;
  // Completion is flagged one cycle early so done_o lands on the final cycle of q3
  assign fin   = (state != S_IDLE) && (qtr == 2'd3) && (cnt == Q_FIN) &&
                 ((state != S_BIT) || (bit_idx == 4'd8));

  // SDA drive for the bit that follows bit_idx; sh has already shifted by then
  always_comb begin
    nbit_oe = 1'b0;
    if (bit_idx == 4'd7)
      nbit_oe = !is_wr && !last_r;
    else if (is_wr)
      nbit_oe = !sh[7];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      qtr         <= '0;
      bit_idx     <= '0;
      is_wr       <= 1'b0;
      last_r      <= 1'b0;
      ack_s       <= 1'b0;
      sh          <= '0;
      scl_oe_o    <= 1'b0;
      sda_oe_o    <= 1'b0;
      cmd_ready_o <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      nack_o      <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          cnt         <= '0;
          qtr         <= '0;
          bit_idx     <= '0;
          if (cmd_valid_i && cmd_ready_o) begin
            if (cmd_i == C_START) begin
              state       <= S_START;
              cmd_ready_o <= 1'b0;
              busy_o      <= 1'b1;
              sda_oe_o    <= 1'b0;
            end else if (!busy_o) begin
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else if (cmd_i == C_STOP) begin
              state       <= S_STOP;
              cmd_ready_o <= 1'b0;
              sda_oe_o    <= 1'b1;
            end else begin
              state       <= S_BIT;
              cmd_ready_o <= 1'b0;
              is_wr       <= (cmd_i == C_WRITE);
              last_r      <= cmd_last_i;
              sh          <= cmd_data_i;
              scl_oe_o    <= 1'b1;
              sda_oe_o    <= (cmd_i == C_WRITE) && !cmd_data_i[7];
            end
          end
        end
        default: begin
          if (fin) begin
            state       <= S_IDLE;
            done_o      <= 1'b1;
            cmd_ready_o <= 1'b1;
            err_o       <= 1'b0;
            if (state == S_STOP)
              busy_o <= 1'b0;
            if (state == S_BIT) begin
              if (is_wr)
                nack_o <= ack_s;
              else
                rd_data_o <= sh;
            end
          end else if (q_end) begin
            cnt <= '0;
            qtr <= qtr + 2'd1;
            if ((state == S_BIT) && (qtr == 2'd2)) begin
              if (bit_idx == 4'd8)
                ack_s <= sda_i;
              else
                sh <= {sh[6:0], sda_i};
            end
            case (qtr)
              2'd0: scl_oe_o <= 1'b0;
              2'd1: begin
                if (state == S_START)
                  sda_oe_o <= 1'b1;
                else if (state == S_STOP)
                  sda_oe_o <= 1'b0;
              end
              2'd2: begin
                if (state != S_STOP)
                  scl_oe_o <= 1'b1;
              end
              2'd3: begin
                // only BIT phases wrap here; START/STOP finish via fin
                bit_idx  <= bit_idx + 4'd1;
                sda_oe_o <= nbit_oe;
              end
            endcase
          end else if (!stall) begin
            cnt <= cnt + 10'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_seq.sv
// tb/tb_i2c_master_seq.sv - self-checking bench for i2c_master_seq (vector table, random ops, corner sequences)
module tb_i2c_master_seq;
  localparam int D  = 4;
  localparam int BQ = 4 * D;

  logic       tb_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_last = 1'b0;
  logic       cmd_ready, done, nack, err, busy, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic       scl_line, sda_line;
  logic       slave_sda_low, slave_scl_hold;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  int         sl_start = 0;
  logic       sl_active = 1'b0;
  int         sl_mode = 0;
  logic [7:0] sl_byte = 8'h00;
  logic       sl_ack = 1'b0;
  logic       sl_stretch = 1'b0;

  logic [8:0] bits = '0;
  int         nbits = 0;

  i2c_master_seq #(.CLK_DIV(D)) dut (
    .wb_clk_i   (tb_clk),
    .wb_rst_n_i (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_i      (cmd),
    .cmd_data_i (cmd_data),
    .cmd_last_i (cmd_last),
    .cmd_ready_o(cmd_ready),
    .done_o     (done),
    .rd_data_o  (rd_data),
    .nack_o     (nack),
    .err_o      (err),
    .busy_o     (busy),
    .scl_i      (scl_line),
    .sda_i      (sda_line),
    .scl_oe_o   (scl_oe),
    .sda_oe_o   (sda_oe)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  assign scl_line = !scl_oe && !slave_scl_hold;
  assign sda_line = !sda_oe && !slave_sda_low;

  // Slave model: bit b of a byte command spans 4*D cycles starting one cycle after acceptance
  always_comb begin
    int rel;
    int b;
    slave_sda_low  = 1'b0;
    slave_scl_hold = 1'b0;
    rel = cyc - sl_start - 1;
    b   = rel / BQ;
    if (sl_active && rel >= 0) begin
      if (sl_mode == 1 && b == 8 && sl_ack)
        slave_sda_low = 1'b1;
      if (sl_mode == 2 && b < 8)
        slave_sda_low = !sl_byte[7 - b];
      if (sl_stretch && rel >= 3 * BQ + 2 * D && rel < 3 * BQ + 2 * D + 20)
        slave_scl_hold = 1'b1;
    end
  end

  // Bus monitor: the SDA level seen at each SCL falling edge is the bit that was clocked
  always @(negedge scl_line) begin
    bits  = {bits[7:0], sda_line};
    nbits = nbits + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic l,
                         output int lat, output int rdy_ok, output int oe_seen);
    int n;
    int acc;
    lat = -1;
    rdy_ok = 1;
    oe_seen = 0;
    @(negedge tb_clk);
    nbits = 0;
    cmd_valid = 1'b1;
    cmd = c;
    cmd_data = d;
    cmd_last = l;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge tb_clk);
      n++;
    end
    acc = cyc;
    sl_start = cyc;
    sl_active = 1'b1;
    @(negedge tb_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (n < 2000) begin
      if (scl_oe || sda_oe) oe_seen = 1;
      if (done) begin
        lat = cyc - acc;
        if (!cmd_ready) rdy_ok = 0;
        break;
      end
      if (cmd_ready) rdy_ok = 0;
      @(negedge tb_clk);
      n++;
    end
    sl_active = 1'b0;
  endtask

  typedef struct {
    logic [1:0] c;
    logic [7:0] d;
    logic       l;
    int         sm;
    logic [7:0] sb;
    logic       sa;
    int         lat;
    logic       e;
    logic       nk;
    logic [7:0] rd;
    logic       bz;
    logic       cb;
    logic [8:0] bv;
  } vec_t;

  vec_t tv[10];

  initial begin
    int lat, rdy_ok, oe_seen, n, acc, done_seen;
    logic [7:0] m_rd;
    logic       m_nk;

    tv[0] = '{2'd2, 8'h00, 1'b0, 0, 8'h00, 1'b0,   1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000};
    tv[1] = '{2'd0, 8'h00, 1'b0, 0, 8'h00, 1'b0,  16, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000};
    tv[2] = '{2'd1, 8'h10, 1'b0, 1, 8'h00, 1'b1, 144, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9'h020};
    tv[3] = '{2'd1, 8'hff, 1'b0, 0, 8'h00, 1'b0, 144, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 9'h1ff};
    tv[4] = '{2'd0, 8'h00, 1'b0, 0, 8'h00, 1'b0,  16, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 9'h000};
    tv[5] = '{2'd1, 8'hcb, 1'b0, 1, 8'h00, 1'b1, 144, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9'h196};
    tv[6] = '{2'd2, 8'h00, 1'b1, 2, 8'h5a, 1'b0, 144, 1'b0, 1'b0, 8'h5a, 1'b1, 1'b1, 9'h0b5};
    tv[7] = '{2'd3, 8'h00, 1'b0, 0, 8'h00, 1'b0,  16, 1'b0, 1'b0, 8'h5a, 1'b0, 1'b0, 9'h000};
    tv[8] = '{2'd3, 8'h00, 1'b0, 0, 8'h00, 1'b0,   1, 1'b1, 1'b0, 8'h5a, 1'b0, 1'b0, 9'h000};
    tv[9] = '{2'd1, 8'h55, 1'b0, 0, 8'h00, 1'b0,   1, 1'b1, 1'b0, 8'h5a, 1'b0, 1'b0, 9'h000};

    repeat (3) @(negedge tb_clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", {scl_oe, sda_oe}, 0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_nack_err", {nack, err}, 0);
    rst_n = 1'b1;
    @(posedge tb_clk);
    #1;
    check("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 10; i++) begin
      sl_mode = tv[i].sm;
      sl_byte = tv[i].sb;
      sl_ack  = tv[i].sa;
      run_cmd(tv[i].c, tv[i].d, tv[i].l, lat, rdy_ok, oe_seen);
      check($sformatf("row%0d_latency", i), lat, tv[i].lat);
      check($sformatf("row%0d_ready", i), rdy_ok, 1);
      check($sformatf("row%0d_err", i), err, tv[i].e);
      check($sformatf("row%0d_nack", i), nack, tv[i].nk);
      check($sformatf("row%0d_rd", i), rd_data, tv[i].rd);
      check($sformatf("row%0d_busy", i), busy, tv[i].bz);
      if (tv[i].cb) begin
        check($sformatf("row%0d_nbits", i), nbits, 9);
        check($sformatf("row%0d_bits", i), bits, tv[i].bv);
      end
      if (!tv[i].bz)
        check($sformatf("row%0d_lines_released", i), {scl_oe, sda_oe}, 0);
      if (tv[i].e)
        check($sformatf("row%0d_no_bus_activity", i), oe_seen, 0);
    end

    // Random byte traffic against a model holding the last read byte and last ACK bit
    m_rd = 8'h5a;
    m_nk = 1'b0;
    sl_mode = 0;
    run_cmd(2'd0, 8'h00, 1'b0, lat, rdy_ok, oe_seen);
    check("rnd_start_latency", lat, BQ);
    for (int i = 0; i < 16; i++) begin
      logic       is_rd;
      logic [7:0] v;
      logic       f;
      is_rd = 1'($urandom_range(0, 1));
      v     = 8'($urandom);
      f     = 1'($urandom_range(0, 1));
      if (is_rd) begin
        sl_mode = 2;
        sl_byte = v;
        run_cmd(2'd2, 8'($urandom), f, lat, rdy_ok, oe_seen);
        m_rd = v;
        check($sformatf("rnd%0d_bits", i), bits, {v, f});
      end else begin
        sl_mode = 1;
        sl_ack  = f;
        run_cmd(2'd1, v, 1'b0, lat, rdy_ok, oe_seen);
        m_nk = !f;
        check($sformatf("rnd%0d_bits", i), bits, {v, !f});
      end
      check($sformatf("rnd%0d_latency", i), lat, 9 * BQ);
      check($sformatf("rnd%0d_rd", i), rd_data, m_rd);
      check($sformatf("rnd%0d_nack", i), nack, m_nk);
      check($sformatf("rnd%0d_err_busy", i), {err, busy}, 2'b01);
    end
    sl_mode = 0;

    // Slave stretches SCL for 20 cycles in q2 of bit 3
    sl_stretch = 1'b1;
    run_cmd(2'd1, 8'h3c, 1'b0, lat, rdy_ok, oe_seen);
    sl_stretch = 1'b0;
`ifdef I2C_MASTER_STRETCH_EN
    check("stretch_latency", lat, 9 * BQ + 20);
`else
    check("stretch_latency", lat, 9 * BQ);
`endif
    run_cmd(2'd3, 8'h00, 1'b0, lat, rdy_ok, oe_seen);
    check("stop_latency", lat, BQ);
    check("stop_busy", busy, 0);

    // Reset in the middle of a WRITE
    run_cmd(2'd0, 8'h00, 1'b0, lat, rdy_ok, oe_seen);
    @(negedge tb_clk);
    cmd_valid = 1'b1;
    cmd = 2'd1;
    cmd_data = 8'h00;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge tb_clk);
      n++;
    end
    acc = cyc;
    @(negedge tb_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (cyc < acc + 3 * BQ + 1 && n < 1000) begin
      @(negedge tb_clk);
      n++;
    end
    check("pre_rst_oe", {scl_oe, sda_oe}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", {scl_oe, sda_oe}, 0);
    check("mid_rst_ready_busy", {cmd_ready, busy}, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge tb_clk);
      if (done) done_seen = 1;
    end
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", cmd_ready, 0);
    @(posedge tb_clk);
    #1;
    check("rel_ready_after_edge", cmd_ready, 1);
    repeat (40) begin
      @(negedge tb_clk);
      if (done) done_seen = 1;
    end
    check("rst_no_done", done_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
